// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the PE driver, its watchdog and the PE itself.
// Holds the driver state encoding and the default operand/product/accumulator
// widths, so the driver and the PE agree on them without repeating literals.
package pe_pkg;

    localparam int PE_PRECISION        = 8;
    localparam int PE_OUTPUT_PRECISION = 32;
    localparam int PE_ACC_WIDTH        = 40;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        POST  = 3'd4,
        DRAIN = 3'd5,
        EMIT  = 3'd6
    } state_e;

endpackage

// File: rtl/pe_watchdog.sv
// pe_watchdog: loadable down-counter that bounds how long the driver waits
// for a PE result.
// Ports:
//   clk_i      clock, posedge
//   rst_ni     synchronous active-low reset
//   load_i     load TIMEOUT_CYCLES-1 (highest priority)
//   clear_i    force the count to zero
//   en_i       count down by one; the count stops at zero
//   expired_o  count is zero
// After a load, expired_o rises on the TIMEOUT_CYCLES-th enabled cycle.
module pe_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(TIMEOUT_CYCLES - 1);
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pe_driver.sv
// pe_driver: issues operand pairs to a single multiply PE, collects the
// products, accumulates them into a dot product and emits the sum when the
// element flagged last completes.
// Ports:
//   CLK, reset_n                     clock / synchronous active-low reset
//   op_a, op_b, op_last, op_valid    operand stream in
//   op_ready                         operand pair accepted this cycle
//   res_data, res_count, res_valid   dot-product result out (held until res_ready)
//   res_ready                        consumer accepts the result
//   pe_a_in, pe_b_in                 operands to the PE
//   pe_start_multiply, pe_ack        one-cycle pulses to the PE
//   pe_s_out, pe_ready               PE product and result-available level
//   err_timeout                      sticky: a PE operation timed out
//   busy                             driver not in IDLE
module pe_driver
    import pe_pkg::*;
#(
    parameter int PRECISION        = PE_PRECISION,
    parameter int OUTPUT_PRECISION = PE_OUTPUT_PRECISION,
    parameter int ACC_WIDTH        = PE_ACC_WIDTH,
    parameter int COUNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic [PRECISION-1:0]        op_a,
    input  logic [PRECISION-1:0]        op_b,
    input  logic                        op_last,
    input  logic                        op_valid,
    output logic                        op_ready,
    output logic [ACC_WIDTH-1:0]        res_data,
    output logic [COUNT_WIDTH-1:0]      res_count,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [PRECISION-1:0]        pe_a_in,
    output logic [PRECISION-1:0]        pe_b_in,
    output logic                        pe_start_multiply,
    input  logic [OUTPUT_PRECISION-1:0] pe_s_out,
    input  logic                        pe_ready,
    output logic                        pe_ack,
    output logic                        err_timeout,
    output logic                        busy
);

    state_e                   state_q, state_d;
    logic                     up_q;
    logic [PRECISION-1:0]     pe_a_q, pe_a_d, pe_b_q, pe_b_d;
    logic                     last_q, last_d;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     start_q, start_d, ack_q, ack_d;
    logic                     res_valid_q, res_valid_d, busy_q, busy_d;
    logic [ACC_WIDTH-1:0]     res_data_q, res_data_d;
    logic [COUNT_WIDTH-1:0]   res_count_q, res_count_d;
    logic                     wd_load, wd_clear, wd_en, wd_expired;

    pe_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_ni   (reset_n),
        .load_i   (wd_load),
        .clear_i  (wd_clear),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    // up_q keeps op_ready low while reset is applied and in the first cycle
    // after release; a stale pe_ready always wins over a new operand.
    assign op_ready = up_q && (state_q == IDLE) && !pe_ready;

    // State register
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pe_ready) begin
                    state_d = DRAIN;
                end else if (op_valid && op_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (pe_ready) begin
                    state_d = ACK;
                end else if (wd_expired) begin
                    state_d = POST;
                end
            end
            ACK:   state_d = POST;
            POST:  state_d = last_q ? EMIT : IDLE;
            DRAIN: state_d = IDLE;
            EMIT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; every output is a decode of state_d
    // so it is registered and lines up with the state it belongs to.
    always_comb begin
        pe_a_d   = pe_a_q;
        pe_b_d   = pe_b_q;
        last_d   = last_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wd_load  = 1'b0;
        wd_clear = 1'b0;
        wd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                wd_clear = 1'b1;
                if (!pe_ready && op_valid && op_ready) begin
                    pe_a_d = op_a;
                    pe_b_d = op_b;
                    last_d = op_last;
                end
            end
            ISSUE: wd_load = 1'b1;
            WAIT: begin
                if (pe_ready) begin
                    acc_d = acc_q + ACC_WIDTH'(pe_s_out);
                    cnt_d = cnt_q + COUNT_WIDTH'(1);
                end else if (wd_expired) begin
                    // Abandoned element still counts, contributing zero.
                    err_d = 1'b1;
                    cnt_d = cnt_q + COUNT_WIDTH'(1);
                end else begin
                    wd_en = 1'b1;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
        start_d     = (state_d == ISSUE);
        ack_d       = (state_d == ACK) || (state_d == DRAIN);
        res_valid_d = (state_d == EMIT);
        res_data_d  = res_valid_d ? acc_d : '0;
        res_count_d = res_valid_d ? cnt_d : '0;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            up_q        <= 1'b0;
            pe_a_q      <= '0;
            pe_b_q      <= '0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            ack_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            up_q        <= 1'b1;
            pe_a_q      <= pe_a_d;
            pe_b_q      <= pe_b_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            start_q     <= start_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            busy_q      <= busy_d;
        end
    end

    assign pe_a_in           = pe_a_q;
    assign pe_b_in           = pe_b_q;
    assign pe_start_multiply = start_q;
    assign pe_ack            = ack_q;
    assign res_valid         = res_valid_q;
    assign res_data          = res_data_q;
    assign res_count         = res_count_q;
    assign err_timeout       = err_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_pe_driver.sv
// Testbench for pe_driver: table of dot-product vectors with a result
// scoreboard, a behavioural PE model, and hand-written sequences for
// reset drain, result back-pressure, timeout and reset during WAIT.
module tb_pe_driver;

    localparam int P  = 8;
    localparam int OP = 32;
    localparam int AW = 40;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          reset_n;
    logic [P-1:0]  op_a, op_b;
    logic          op_last, op_valid, op_ready;
    logic [AW-1:0] res_data;
    logic [CW-1:0] res_count;
    logic          res_valid, res_ready;
    logic [P-1:0]  pe_a_in, pe_b_in;
    logic          pe_start_multiply, pe_ack, err_timeout, busy;
    logic [OP-1:0] pe_s_out = '0;
    logic          pe_ready = 1'b1;   // PE powers up with a stale result
    logic          pe_mute, pe_release;
    logic          late_pending = 1'b0;

    pe_driver dut (
        .CLK(CLK), .reset_n(reset_n),
        .op_a(op_a), .op_b(op_b), .op_last(op_last), .op_valid(op_valid), .op_ready(op_ready),
        .res_data(res_data), .res_count(res_count), .res_valid(res_valid), .res_ready(res_ready),
        .pe_a_in(pe_a_in), .pe_b_in(pe_b_in), .pe_start_multiply(pe_start_multiply),
        .pe_s_out(pe_s_out), .pe_ready(pe_ready), .pe_ack(pe_ack),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // PE model: one-cycle response, ready held until ack. When muted the
    // result is withheld until pe_release is pulsed.
    always @(posedge CLK) begin
        if (pe_ack) pe_ready <= 1'b0;
        if (pe_start_multiply) begin
            if (pe_mute) begin
                late_pending <= 1'b1;
            end else begin
                pe_ready <= 1'b1;
                pe_s_out <= 32'(pe_a_in) * 32'(pe_b_in);
            end
        end else if (pe_release && late_pending) begin
            pe_ready     <= 1'b1;
            pe_s_out     <= 32'd5555;
            late_pending <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [CW-1:0] c;
    } exp_t;
    exp_t sbq[$];

    typedef struct packed {
        logic [2:0]        n;
        logic [3:0][P-1:0] a;
        logic [3:0][P-1:0] b;
        logic [AW-1:0]     exp;
    } vec_t;
    vec_t tbl[5];

    int checks = 0, errors = 0;
    int pv = 0, ack_cnt = 0;
    int last_start_cyc = 0, last_ack_cyc = 0, rv_cyc = 0;
    int acc_cyc[4];
    logic prev_start = 0, prev_ack = 0, prev_rv = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Monitor: latency bookkeeping, protocol rules, scoreboard pop.
    always @(negedge CLK) begin
        if (pe_start_multiply) last_start_cyc = cyc;
        if (pe_ack) begin
            last_ack_cyc = cyc;
            ack_cnt++;
        end
        if (res_valid && !prev_rv) rv_cyc = cyc;
        if (pe_start_multiply && pe_ack) pv++;
        if (pe_start_multiply && prev_start) pv++;
        if (pe_ack && prev_ack) pv++;
        if (pe_start_multiply && pe_ready) pv++;
        if (op_ready && pe_ready) pv++;
        if (res_valid && res_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("res_data", 64'(res_data), 64'(e.d));
                chk("res_count", 64'(res_count), 64'(e.c));
            end
        end
        prev_start = pe_start_multiply;
        prev_ack   = pe_ack;
        prev_rv    = res_valid;
    end

    task automatic send_elem(input logic [P-1:0] a, input logic [P-1:0] b,
                             input logic l, output int acc_c);
        int k;
        op_a = a; op_b = b; op_last = l; op_valid = 1'b1;
        k = 0;
        while (!op_ready && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (!op_ready) chk("accept_timeout", 0, 1);
        acc_c = cyc;
        @(negedge CLK);
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic run_vector(input int n, input logic [3:0][P-1:0] a,
                              input logic [3:0][P-1:0] b, input bit push,
                              input logic [AW-1:0] exp);
        int t;
        if (push) sbq.push_back('{exp, CW'(n)});
        for (int i = 0; i < n; i++) begin
            send_elem(a[i], b[i], (i == n - 1), t);
            acc_cyc[i] = t;
        end
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) @(negedge CLK);
        chk("result_wait_timeout", 64'(sbq.size()), 0);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "global timeout");
    end

    initial begin
        int a0;
        tbl[0] = '{3'd1, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd4}, 40'd12};
        tbl[1] = '{3'd3, {8'd0, 8'd3, 8'd2, 8'd1}, {8'd0, 8'd6, 8'd5, 8'd4}, 40'd32};
        tbl[2] = '{3'd2, {8'd0, 8'd0, 8'd7, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd9}, 40'd0};
        tbl[3] = '{3'd4, {8'd255, 8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255, 8'd255}, 40'd260100};
        tbl[4] = '{3'd2, {8'd0, 8'd0, 8'd100, 8'd200}, {8'd0, 8'd0, 8'd3, 8'd2}, 40'd700};

        reset_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_last = 1'b0;
        res_ready = 1'b1; pe_mute = 1'b0; pe_release = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pe_ack", pe_ack, 0);
        chk("rst_pe_start", pe_start_multiply, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_op_ready", op_ready, 0);

        // Stale PE result at reset release is drained with one ack.
        a0 = ack_cnt;
        reset_n = 1'b1;
        repeat (8) @(negedge CLK);
        chk("drain_ack_count", 64'(ack_cnt - a0), 1);
        chk("drain_op_ready", op_ready, 1);
        chk("drain_no_result", res_valid, 0);

        for (int v = 0; v < 5; v++) begin
            run_vector(int'(tbl[v].n), tbl[v].a, tbl[v].b, 1'b1, tbl[v].exp);
            wait_empty(400);
            if (v == 0) begin
                chk("start_latency", 64'(last_start_cyc - acc_cyc[0]), 1);
                chk("ack_latency", 64'(last_ack_cyc - acc_cyc[0]), 3);
                chk("result_latency_1", 64'(rv_cyc - acc_cyc[0]), 5);
            end
            if (v == 1) begin
                chk("elem_spacing_1", 64'(acc_cyc[1] - acc_cyc[0]), 5);
                chk("elem_spacing_2", 64'(acc_cyc[2] - acc_cyc[1]), 5);
                chk("result_latency_3", 64'(rv_cyc - acc_cyc[0]), 15);
            end
        end

        // Back-pressure: result held for 6 cycles.
        res_ready = 1'b0;
        run_vector(2, {8'd0, 8'd0, 8'd20, 8'd10}, {8'd0, 8'd0, 8'd40, 8'd30}, 1'b1, 40'd1100);
        for (int k = 0; k < 100 && !res_valid; k++) @(negedge CLK);
        chk("hold_seen", res_valid, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 1100);
            chk("hold_count", res_count, 2);
            chk("hold_op_ready", op_ready, 0);
        end
        res_ready = 1'b1;
        wait_empty(50);
        run_vector(1, {24'd0, 8'd255}, {24'd0, 8'd255}, 1'b1, 40'd65025);
        wait_empty(100);

        // Timeout: PE silent, element counts but adds zero.
        pe_mute = 1'b1;
        run_vector(1, {24'd0, 8'd9}, {24'd0, 8'd9}, 1'b1, 40'd0);
        wait_empty(300);
        chk("timeout_result_latency", 64'(rv_cyc - acc_cyc[0]), 67);
        chk("timeout_err", err_timeout, 1);
        a0 = ack_cnt;
        repeat (2) @(negedge CLK);
        pe_release = 1'b1;
        @(negedge CLK);
        pe_release = 1'b0;
        pe_mute = 1'b0;
        repeat (6) @(negedge CLK);
        chk("late_drain_ack", 64'(ack_cnt - a0), 1);
        run_vector(1, {24'd0, 8'd3}, {24'd0, 8'd4}, 1'b1, 40'd12);
        wait_empty(100);
        chk("err_sticky", err_timeout, 1);

        // Reset while waiting on the PE.
        pe_mute = 1'b1;
        run_vector(1, {24'd0, 8'd6}, {24'd0, 8'd6}, 1'b0, 40'd0);
        repeat (4) @(negedge CLK);
        chk("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        @(negedge CLK);
        chk("wrst_busy", busy, 0);
        chk("wrst_err", err_timeout, 0);
        chk("wrst_res_valid", res_valid, 0);
        chk("wrst_pe_start", pe_start_multiply, 0);
        chk("wrst_pe_ack", pe_ack, 0);
        chk("wrst_pe_a_in", pe_a_in, 0);
        chk("wrst_op_ready", op_ready, 0);
        reset_n = 1'b1;
        a0 = ack_cnt;
        @(negedge CLK);
        pe_release = 1'b1;
        @(negedge CLK);
        pe_release = 1'b0;
        pe_mute = 1'b0;
        repeat (6) @(negedge CLK);
        chk("wrst_drain_ack", 64'(ack_cnt - a0), 1);
        run_vector(1, {24'd0, 8'd2}, {24'd0, 8'd7}, 1'b1, 40'd14);
        wait_empty(100);

        chk("protocol_violations", 64'(pv), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
